// File: rtl/pipe_pkg.sv
// Shared types and default latencies for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 32;

endpackage

// File: rtl/muldiv_seq.sv
// Issue/busy sequencer for the multi-cycle mult/div unit.
// Busy covers exactly LAT cycles after the issue edge; new issue only from IDLE.
module muldiv_seq
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic is_div,
    input  logic stall,
    output logic start,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DIV_LAT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             fire;

    // Issue is suppressed during reset and whenever the pipeline stalls.
    assign fire = rst & issue & ~stall & (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (fire) begin
                    state_nxt = BUSY;
                    cnt_nxt   = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE: start = fire;
            BUSY: busy  = rst;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble generation for the 5-stage pipeline plus mult/div sequencing.
// Optional stall performance counter enabled by PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic        id_is_muldiv,
    input  logic        id_is_div,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_wreg,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_wreg,
    output logic        pc_wena,
    output logic        if_id_wena,
    output logic        id_ex_bubble,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic [31:0] stall_cycles
);

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_haz;
    logic md_haz;
    logic stall;

    // $0 is hardwired, so it never creates a dependency.
    assign ex_hit  = (ex_wreg != REG_ZERO)
                   & ((id_uses_rs & (id_rs == ex_wreg)) | (id_uses_rt & (id_rt == ex_wreg)));
    assign mem_hit = (mem_wreg != REG_ZERO)
                   & ((id_uses_rs & (id_rs == mem_wreg)) | (id_uses_rt & (id_rt == mem_wreg)));

    assign load_use = ex_mem_read & ex_hit;
    assign br_haz   = id_is_branch & ((ex_reg_write & ex_hit) | (mem_mem_read & mem_hit));
    assign md_haz   = muldiv_busy & (id_is_muldiv | id_reads_hilo);
    assign stall    = load_use | br_haz | md_haz;

    assign pc_wena      = rst & ~stall;
    assign if_id_wena   = rst & ~stall;
    assign id_ex_bubble = rst & stall;

    muldiv_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_muldiv_seq (
        .clk    (clk),
        .rst    (rst),
        .issue  (id_is_muldiv),
        .is_div (id_is_div),
        .stall  (stall),
        .start  (muldiv_start),
        .busy   (muldiv_busy)
    );

`ifdef PIPE_CTRL_PERF_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, monitor compares.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 32;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       id_is_branch;
        logic       id_is_muldiv;
        logic       id_is_div;
        logic       id_reads_hilo;
        logic       ex_mem_read;
        logic       ex_reg_write;
        logic [4:0] ex_wreg;
        logic       mem_mem_read;
        logic [4:0] mem_wreg;
    } stim_t;

    typedef struct packed {
        logic        pc_wena;
        logic        if_id_wena;
        logic        id_ex_bubble;
        logic        muldiv_start;
        logic        muldiv_busy;
        logic [31:0] stall_cycles;
    } exp_t;

    logic        clk = 1'b0;
    stim_t       s;
    logic        pc_wena, if_id_wena, id_ex_bubble, muldiv_start, muldiv_busy;
    logic [31:0] stall_cycles;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // reference model state: cycles of busy left, saturating stall tally
    int          busy_left = 0;
    logic [31:0] perf = 32'd0;
    bit          prev_start = 1'b0;
    bit          prev_stall = 1'b0;
    int          prev_lat = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk           (clk),
        .rst           (s.rst),
        .id_rs         (s.id_rs),
        .id_rt         (s.id_rt),
        .id_uses_rs    (s.id_uses_rs),
        .id_uses_rt    (s.id_uses_rt),
        .id_is_branch  (s.id_is_branch),
        .id_is_muldiv  (s.id_is_muldiv),
        .id_is_div     (s.id_is_div),
        .id_reads_hilo (s.id_reads_hilo),
        .ex_mem_read   (s.ex_mem_read),
        .ex_reg_write  (s.ex_reg_write),
        .ex_wreg       (s.ex_wreg),
        .mem_mem_read  (s.mem_mem_read),
        .mem_wreg      (s.mem_wreg),
        .pc_wena       (pc_wena),
        .if_id_wena    (if_id_wena),
        .id_ex_bubble  (id_ex_bubble),
        .muldiv_start  (muldiv_start),
        .muldiv_busy   (muldiv_busy),
        .stall_cycles  (stall_cycles)
    );

    function automatic stim_t nop();
        stim_t t;
        t     = '0;
        t.rst = 1'b1;
        return t;
    endfunction

    function automatic bit reads(input stim_t t, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (t.id_uses_rs && t.id_rs == r) || (t.id_uses_rt && t.id_rt == r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pipeline cycle: advance the model across the edge, apply inputs, queue expectation.
    task automatic step(input stim_t n);
        exp_t e;
        bit   busy, lu, bh, mh, st, start;
        @(posedge clk);
        if (!s.rst) begin
            busy_left = 0;
            perf      = 32'd0;
        end else begin
            if (prev_start) busy_left = prev_lat;
            else if (busy_left > 0) busy_left--;
`ifdef PIPE_CTRL_PERF_EN
            if (prev_stall && perf != 32'hFFFF_FFFF) perf = perf + 32'd1;
`endif
        end
        #1;
        s     = n;
        busy  = s.rst && (busy_left > 0);
        lu    = s.ex_mem_read && reads(s, s.ex_wreg);
        bh    = s.id_is_branch && ((s.ex_reg_write && reads(s, s.ex_wreg))
                                || (s.mem_mem_read && reads(s, s.mem_wreg)));
        mh    = busy && (s.id_is_muldiv || s.id_reads_hilo);
        st    = lu || bh || mh;
        start = s.rst && !busy && s.id_is_muldiv && !st;
        e.pc_wena      = s.rst && !st;
        e.if_id_wena   = s.rst && !st;
        e.id_ex_bubble = s.rst && st;
        e.muldiv_start = start;
        e.muldiv_busy  = busy;
        e.stall_cycles = perf;
        sb_q.push_back(e);
        prev_start = start;
        prev_stall = s.rst && st;
        prev_lat   = s.id_is_div ? int'(DIV_LAT) : int'(MUL_LAT);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_wena",      32'(pc_wena),      32'(e.pc_wena));
                chk("if_id_wena",   32'(if_id_wena),   32'(e.if_id_wena));
                chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.id_ex_bubble));
                chk("muldiv_start", 32'(muldiv_start), 32'(e.muldiv_start));
                chk("muldiv_busy",  32'(muldiv_busy),  32'(e.muldiv_busy));
                chk("stall_cycles", stall_cycles,      e.stall_cycles);
            end
        end
    end

    initial begin : driver
        stim_t t;
        s     = nop();
        s.rst = 1'b0;
        t     = s;
        step(t);
        step(t);

        // load-use: EX lw $5, ID add $6,$5,$1
        t = nop();
        t.ex_mem_read = 1'b1; t.ex_reg_write = 1'b1; t.ex_wreg = 5'd5;
        t.id_rs = 5'd5; t.id_rt = 5'd1; t.id_uses_rs = 1'b1; t.id_uses_rt = 1'b1;
        step(t);
        t.ex_mem_read = 1'b0; t.ex_reg_write = 1'b0; t.ex_wreg = 5'd0;
        t.mem_mem_read = 1'b1; t.mem_wreg = 5'd5;
        step(t);

        // branch after ALU producer
        t = nop();
        t.ex_reg_write = 1'b1; t.ex_wreg = 5'd3;
        t.id_is_branch = 1'b1; t.id_rs = 5'd3; t.id_rt = 5'd4;
        t.id_uses_rs = 1'b1; t.id_uses_rt = 1'b1;
        step(t);
        t.ex_reg_write = 1'b0; t.ex_wreg = 5'd0; t.mem_wreg = 5'd3;
        step(t);

        // branch after load: two stalls
        t = nop();
        t.ex_mem_read = 1'b1; t.ex_reg_write = 1'b1; t.ex_wreg = 5'd3;
        t.id_is_branch = 1'b1; t.id_rs = 5'd3; t.id_rt = 5'd4;
        t.id_uses_rs = 1'b1; t.id_uses_rt = 1'b1;
        step(t);
        t.ex_mem_read = 1'b0; t.ex_reg_write = 1'b0; t.ex_wreg = 5'd0;
        t.mem_mem_read = 1'b1; t.mem_wreg = 5'd3;
        step(t);
        t.mem_mem_read = 1'b0; t.mem_wreg = 5'd0;
        step(t);

        // $0 never matches
        t = nop();
        t.ex_mem_read = 1'b1; t.ex_reg_write = 1'b1; t.ex_wreg = 5'd0;
        t.id_is_branch = 1'b1; t.id_uses_rs = 1'b1; t.id_uses_rt = 1'b1;
        t.mem_mem_read = 1'b1; t.mem_wreg = 5'd0;
        step(t);

        // mult, then mflo waits for the busy window
        t = nop(); t.id_is_muldiv = 1'b1;
        step(t);
        t = nop(); t.id_reads_hilo = 1'b1;
        for (int i = 0; i < 6; i++) step(t);

        // div aborted by reset at busy cycle 10, then mult issues
        t = nop(); t.id_is_muldiv = 1'b1; t.id_is_div = 1'b1;
        step(t);
        t = nop(); t.id_reads_hilo = 1'b1;
        for (int i = 0; i < 9; i++) step(t);
        t.rst = 1'b0;
        step(t);
        t = nop(); t.id_is_muldiv = 1'b1;
        step(t);
        t = nop();
        for (int i = 0; i < 6; i++) step(t);

        // randomized traffic with small register range to provoke hits
        for (int i = 0; i < 3000; i++) begin
            t = nop();
            t.rst           = ($urandom_range(0, 199) != 0);
            t.id_rs         = 5'($urandom_range(0, 7));
            t.id_rt         = 5'($urandom_range(0, 7));
            t.id_uses_rs    = 1'($urandom_range(0, 1));
            t.id_uses_rt    = 1'($urandom_range(0, 1));
            t.id_is_branch  = ($urandom_range(0, 3) == 0);
            t.id_is_muldiv  = ($urandom_range(0, 5) == 0);
            t.id_is_div     = ($urandom_range(0, 2) == 0);
            t.id_reads_hilo = ($urandom_range(0, 5) == 0);
            t.ex_mem_read   = ($urandom_range(0, 2) == 0);
            t.ex_reg_write  = 1'($urandom_range(0, 1));
            t.ex_wreg       = 5'($urandom_range(0, 7));
            t.mem_mem_read  = ($urandom_range(0, 2) == 0);
            t.mem_wreg      = 5'($urandom_range(0, 7));
            step(t);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It combines three stall sources into the write enables for the PC register and the IF/ID register, and a bubble request for ID/EX:
- load-use on EX operands,
- branch operands resolved in ID,
- occupancy of the multi-cycle mult/div unit.

It also sequences the mult/div unit through an issue/busy state machine. Branch delay-slot semantics are kept, so IF/ID is never flushed.

## Interface
Parameters:
- MUL_LAT, 4, cycles mult occupies HI/LO (≥2)
- DIV_LAT, 32, cycles div occupies HI/LO (≥2, ≥MUL_LAT)

Ports:
- clk  in  1  pipeline clock; the only clock
- rst  in  1  reset, synchronous and active-low (0 = reset)
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_is_branch  in  1  ID instruction is a branch/jr that compares or reads registers in ID
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_is_div  in  1  qualifies id_is_muldiv (1 = div/divu)
- id_reads_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- ex_mem_read, ex_reg_write  in  1  EX instruction is a load / writes the register file
- ex_wreg  in  5  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_wreg  in  5  MEM destination register
- pc_wena  out  1  PC write enable
- if_id_wena  out  1  drives IF/ID wena
- id_ex_bubble  out  1  ID/EX loads a NOP this edge
- muldiv_start  out  1  single-cycle issue pulse to the mult/div unit
- muldiv_busy  out  1  mult/div unit occupied
- stall_cycles  out  32  performance counter (see Configuration)

## Operation
- Register 0 never matches in any hazard compare.
- rs_hit(r) = id_uses_rs & (id_rs == r) & (r != 0); rt_hit is defined the same way. hit(r) = rs_hit(r) | rt_hit(r).
- load_use = ex_mem_read & hit(ex_wreg).
- br_haz = id_is_branch & ((ex_reg_write & hit(ex_wreg)) | (mem_mem_read & hit(mem_wreg))).
  - An ALU producer in EX costs 1 stall cycle.
  - A load in EX costs 2 cycles: load_use, then the mem_mem_read term.
- md_haz = muldiv_busy & (id_is_muldiv | id_reads_hilo).
- stall = load_use | br_haz | md_haz.
- Outputs from stall:
  - pc_wena = if_id_wena = ~stall
  - id_ex_bubble = stall
- All five signals above are combinational from current inputs and state.
- State machine:
  - IDLE: muldiv_busy = 0. If id_is_muldiv & ~stall: assert muldiv_start, load cnt = (id_is_div ? DIV_LAT : MUL_LAT) − 1, and go to BUSY.
  - BUSY: muldiv_busy = 1. If cnt == 0, go to IDLE next edge; otherwise cnt decrements.
  - Result: busy lasts exactly LAT cycles after the issue edge. A new issue is possible only from IDLE, so back-to-back mult/div has a gap of at least one cycle after BUSY ends.
- cnt width is $clog2(DIV_LAT).
- Priority: stall overrides everything. A branch in ID under stall simply holds; branch_taken is not consumed here.

## Timing
- While rst = 0:
  - pc_wena = 0, if_id_wena = 0, id_ex_bubble = 0, muldiv_start = 0
  - state ← IDLE, cnt ← 0, muldiv_busy = 0, stall_cycles ← 0
- Reset during BUSY aborts the operation at that edge; no muldiv_start is issued in the reset cycle.
- muldiv_start is high for at most 1 cycle and never together with stall.
- Stall outputs have zero-cycle latency relative to their inputs. State changes take effect on the next clk rising edge.
- No internal combinational loop: stall does not depend on muldiv_start.

## Configuration
- PIPE_CTRL_PERF_EN:
  - Defined: stall_cycles increments by 1 each non-reset cycle with stall = 1 and saturates at 32'hFFFF_FFFF.
  - Undefined: stall_cycles is tied to 0 and no counter flops are generated.

## Structure
- Shared package (pipe_pkg) holds:
  - typedef state_t {IDLE, BUSY}
  - REG_ZERO = 5'd0
  - default MUL_LAT / DIV_LAT localparams
- One sub-module, muldiv_seq: the IDLE/BUSY state machine and counter. Inputs are issue request, is_div and stall; outputs are muldiv_start and muldiv_busy.
- Hazard compares stay in the top level.

## Test plan
- Load-use: EX `lw $5`, ID `add $6,$5,$1` → exactly 1 cycle of stall (pc_wena = 0, id_ex_bubble = 1), then release.
- Branch hazards:
  - EX `add $3,...`, ID `beq $3,$4` → 1 stall cycle.
  - EX `lw $3`, ID `beq $3,$4` → 2 stall cycles.
- $0: EX `lw $0`, ID reads $0 → no stall.
- Mult occupancy: `mult` issues with muldiv_start = 1 for 1 cycle, then muldiv_busy is high for 4 cycles; `mflo` in ID during busy → stalled for the remaining busy cycles, then proceeds.
- Divide under reset: `div` issued → busy for 32 cycles; rst = 0 at busy cycle 10 → IDLE and busy = 0 after that edge; a following `mult` issues normally.
- Performance counter: with PIPE_CTRL_PERF_EN defined, 7 total stall cycles → stall_cycles = 7; with it undefined → stall_cycles = 0.
